// File: rtl/param_shift_reg_if.sv
// Bus bundle for param_shift_reg: serial/parallel data in, stage contents and tap out.
// The DUT side uses the slave modport and the driver side uses the master modport.
interface param_shift_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SelW = $clog2(DEPTH);

  logic [WIDTH-1:0]       din;
  logic                   shift_en;
  logic                   rot;
  logic                   load;
  logic [DEPTH*WIDTH-1:0] par_in;
  logic [SelW-1:0]        tap_sel;
  logic [DEPTH*WIDTH-1:0] dout;
  logic [CntW-1:0]        fill_cnt;
  logic                   full;
  logic [WIDTH-1:0]       tap_out;

  modport master (
    output din, shift_en, rot, load, par_in, tap_sel,
    input  dout, fill_cnt, full, tap_out
  );

  modport slave (
    input  din, shift_en, rot, load, par_in, tap_sel,
    output dout, fill_cnt, full, tap_out
  );
endinterface

// File: rtl/param_shift_reg.sv
// Parameterised shift/rotate register with parallel load, fill counter and optional tap.
// Define PARAM_SHIFT_REG_TAP_EN to build the registered tap path; otherwise tap_out is zero.
module param_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  param_shift_reg_if.slave bus
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FillMax = CntW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CntW-1:0]             fill_q, fill_d;
  logic                        full_q, full_d;

  // Load beats shift; rotate recirculates the last stage and leaves the fill level alone.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (bus.load) begin
      stage_d = bus.par_in;
      fill_d  = FillMax;
    end else if (bus.shift_en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        stage_d[i] = stage_q[i-1];
      end
      stage_d[0] = bus.rot ? stage_q[DEPTH-1] : bus.din;
      if (!bus.rot && (fill_q != FillMax)) begin
        fill_d = fill_q + CntW'(1);
      end
    end
    full_d = (fill_d == FillMax);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
    end
  end

  assign bus.dout     = stage_q;
  assign bus.fill_cnt = fill_q;
  assign bus.full     = full_q;

`ifdef PARAM_SHIFT_REG_TAP_EN
  logic [WIDTH-1:0] tap_q, tap_d;

  // Out-of-range selects read as zero rather than aliasing onto a real stage.
  always_comb begin
    tap_d = '0;
    if (int'(bus.tap_sel) < int'(DEPTH)) begin
      tap_d = stage_q[bus.tap_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tap_q <= '0;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign bus.tap_out = tap_q;
`else
  logic unused_tap_sel;
  assign unused_tap_sel = ^bus.tap_sel;
  assign bus.tap_out    = '0;
`endif

endmodule

// File: tb/tb_param_shift_reg.sv
// Randomised and directed bench for param_shift_reg (WIDTH=8, DEPTH=4) against a queue model.
// Tap expectations follow PARAM_SHIFT_REG_TAP_EN as defined for the build.
module tb_param_shift_reg;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
`ifdef PARAM_SHIFT_REG_TAP_EN
  localparam bit TapEn = 1'b1;
`else
  localparam bit TapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_shift_reg_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 of the queue is stage 0 (newest data).
  logic [W-1:0] m_q[$];
  int           m_fill;
  logic [W-1:0] m_tap;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [D*W-1:0] model_dout();
    logic [D*W-1:0] v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = m_q[i];
    return v;
  endfunction

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < D; i++) m_q.push_back('0);
    m_fill = 0;
    m_tap  = '0;
  endtask

  // Advance model and DUT by one rising edge, then compare every output.
  task automatic tick(input string tag);
    logic [W-1:0] last;
    if (!reset) begin
      model_clear();
    end else begin
      m_tap = (TapEn && (int'(bus.tap_sel) < D)) ? m_q[int'(bus.tap_sel)] : '0;
      if (bus.load) begin
        for (int i = 0; i < D; i++) m_q[i] = bus.par_in[i*W +: W];
        m_fill = D;
      end else if (bus.shift_en) begin
        last = m_q.pop_back();
        if (bus.rot) begin
          m_q.push_front(last);
        end else begin
          m_q.push_front(bus.din);
          m_fill = (m_fill + 1 > D) ? D : m_fill + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_val({tag, ".dout"}, 64'(bus.dout), 64'(model_dout()));
    check_val({tag, ".fill"}, 64'(bus.fill_cnt), 64'(m_fill));
    check_val({tag, ".full"}, 64'(bus.full), 64'(m_fill == D));
    check_val({tag, ".tap"}, 64'(bus.tap_out), 64'(m_tap));
  endtask

  task automatic drive(input logic ld, input logic sh, input logic rt, input logic [W-1:0] d);
    bus.load     = ld;
    bus.shift_en = sh;
    bus.rot      = rt;
    bus.din      = d;
  endtask

  initial begin
    model_clear();
    reset       = 1'b0;
    bus.par_in  = '0;
    bus.tap_sel = '0;
    drive(1'b1, 1'b1, 1'b0, 8'h5A);
    tick("reset");
    check_val("reset_dout", 64'(bus.dout), 64'h0);
    reset = 1'b1;

    for (int v = 8'h11; v <= 8'h14; v++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(v));
      tick("fill");
    end
    check_val("fill4_dout", 64'(bus.dout), 64'h11121314);
    check_val("fill4_full", 64'(bus.full), 64'h1);

    drive(1'b0, 1'b1, 1'b0, 8'h15);
    tick("shift_full");
    check_val("drop_oldest", 64'(bus.dout), 64'h12131415);

    drive(1'b0, 1'b1, 1'b1, 8'hAA);
    tick("rotate");
    check_val("rotate_dout", 64'(bus.dout), 64'h13141512);

    bus.par_in = 32'h44332211;
    drive(1'b1, 1'b1, 1'b0, 8'h99);
    tick("load");
    check_val("load_dout", 64'(bus.dout), 64'h44332211);

    bus.tap_sel = 2'd2;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick("tap");
    check_val("tap_sel2", 64'(bus.tap_out), TapEn ? 64'h33 : 64'h0);

    // A reset pulse between edges must not disturb state.
    reset = 1'b0;
    #2;
    check_val("async_pulse", 64'(bus.dout), 64'h44332211);
    reset = 1'b1;
    tick("after_pulse");

    reset = 1'b0;
    tick("mid_reset");
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(8'h60 + k));
      tick("two_shifts");
    end
    check_val("two_fill", 64'(bus.fill_cnt), 64'd2);
    reset = 1'b0;
    tick("reset2");
    check_val("reset2_fill", 64'(bus.fill_cnt), 64'd0);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h77);
    tick("post_reset");
    check_val("post_reset_dout", 64'(bus.dout), 64'h77);
    check_val("post_reset_fill", 64'(bus.fill_cnt), 64'd1);

    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 29) != 0);
      bus.par_in  = {$urandom(), $urandom()};
      bus.tap_sel = 2'($urandom_range(0, D - 1));
      drive(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 2) == 0), 8'($urandom()));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
